bcd_decoder: RTL and testbench

Sequential BCD-to-decimal decoder: the decode-side counterpart of the team's 9-input BCD priority encoder. Accepts a packed multi-digit BCD word over a valid/ready handshake, then emits it one digit per handshake as a decimal one-hot vector in the encoder's `[9:1]` input format, most-significant digit first. Flags non-BCD codes and keeps a saturating error count. Sits between a BCD data source and display or decimal-bus logic.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_decode.sv | 22 ++
 rtl/bcd_decoder.sv | 110 +++++++++++
 tb/tb_bcd_decoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants, used by the encoder/decoder pair and their benches.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [9:1] decimal_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bcd_dec_state_t;

    localparam int BCD_MAX_DIGIT = 9;

    // Codes 10-15 are not decimal digits.
    function automatic logic is_bcd(input bcd_digit_t digit);
        return digit <= bcd_digit_t'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational single-digit decoder: BCD code to one-hot [9:1] decimal plus
// an invalid-code flag. Digit 0 and invalid codes both give an all-zero vector.
module bcd_digit_decode (
    input  logic [3:0] digit,
    output logic [9:1] decimal,
    output logic       error
);
    import bcd_pkg::*;

    bcd_digit_t digit_t;

    assign digit_t = bcd_digit_t'(digit);

    generate
        for (genvar gi = 1; gi <= BCD_MAX_DIGIT; gi++) begin : g_onehot
            assign decimal[gi] = (digit_t == bcd_digit_t'(gi));
        end
    endgenerate

    assign error = !is_bcd(digit_t);

endmodule

// File: rtl/bcd_decoder.sv
// Sequential BCD word decoder: accepts a packed word, then emits one decimal
// one-hot digit per handshake, most-significant digit first.
module bcd_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [9:1]              decimal_out,
    output logic [IDX_W-1:0]        digit_index,
    output logic                    out_error,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    error_count
);
    import bcd_pkg::*;

    // Digit slots are padded to a power of two so the index never selects
    // outside the array, whatever NUM_DIGITS is.
    localparam int SLOTS = 1 << IDX_W;

    bcd_dec_state_t          state_reg, state_next;
    logic [4*NUM_DIGITS-1:0] word_reg, word_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [ERR_CNT_W-1:0]    err_cnt_reg, err_cnt_next;

    bcd_digit_t digit_slot [SLOTS];
    bcd_digit_t sel_digit;
    decimal_t   sel_decimal;
    logic       sel_error;
    logic       emit;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_DIGITS) begin : g_used
                assign digit_slot[gi] = word_reg[4*gi +: 4];
            end else begin : g_pad
                assign digit_slot[gi] = '0;
            end
        end
    endgenerate

    assign sel_digit = digit_slot[idx_reg];

    bcd_digit_decode u_digit_decode (
        .digit   (sel_digit),
        .decimal (sel_decimal),
        .error   (sel_error)
    );

    // Outputs come only from registered state; gating by EMIT keeps them at
    // their reset values whenever nothing is being presented.
    assign emit        = (state_reg == EMIT);
    assign in_ready    = !emit;
    assign out_valid   = emit;
    assign decimal_out = emit ? sel_decimal : '0;
    assign out_error   = emit & sel_error;
    assign out_last    = emit & (idx_reg == '0);
    assign digit_index = emit ? idx_reg : '0;
    assign error_count = err_cnt_reg;

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        idx_next     = idx_reg;
        err_cnt_next = err_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    word_next  = bcd_in;
                    idx_next   = IDX_W'(NUM_DIGITS - 1);
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg - 1'b1;
                    end
                    if (sel_error && (err_cnt_reg != '1)) begin
                        err_cnt_next = err_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            word_reg    <= '0;
            idx_reg     <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            idx_reg     <= idx_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_bcd_decoder.sv
// Randomized self-checking bench for bcd_decoder (NUM_DIGITS=4, ERR_CNT_W=8).
module tb_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        in_valid;
    logic        in_ready;
    logic [9:1]  decimal_out;
    logic [1:0]  digit_index;
    logic        out_error;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    always #5 clk = ~clk;

    bcd_decoder #(.NUM_DIGITS(4), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .decimal_out (decimal_out),
        .digit_index (digit_index),
        .out_error   (out_error),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .error_count (error_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: digit n lights bit n, 0 and non-decimal codes light nothing.
    function automatic logic [8:0] model_dec(input int code);
        if (code >= 1 && code <= 9) return 9'(1) << (code - 1);
        return 9'd0;
    endfunction

    function automatic int model_count();
        return (model_err > 255) ? 255 : model_err;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},    32'(in_ready), 32'd1);
        check({tag, "_out_valid"},   32'(out_valid), 32'd0);
        check({tag, "_decimal"},     32'(decimal_out), 32'd0);
        check({tag, "_out_error"},   32'(out_error), 32'd0);
        check({tag, "_out_last"},    32'(out_last), 32'd0);
        check({tag, "_digit_index"}, 32'(digit_index), 32'd0);
        check({tag, "_error_count"}, 32'(error_count), 32'd0);
    endtask

    // mode 0: always ready; 1: random ready; 2: three stall cycles at digit 2.
    // abort_at >= 0 applies an async reset once that digit is presented.
    task automatic run_word(input logic [15:0] w, input int mode, input int abort_at,
                            input bit hold_valid);
        int k;
        int guard;
        int stall;
        int code;
        bcd_in   = w;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold_valid) in_valid = 1'b0;
        k     = 3;
        stall = 0;
        guard = 0;
        while (k >= 0 && guard < 200) begin
            guard++;
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset_values("midword_rst");
                model_err = 0;
                @(posedge clk); #1;
                rst      = 1'b0;
                in_valid = 1'b0;
                $display("word %h aborted by reset at digit %0d", w, k);
                return;
            end
            code = int'((w >> (4 * k)) & 16'hF);
            check("out_valid",   32'(out_valid), 32'd1);
            check("in_ready_emit", 32'(in_ready), 32'd0);
            check("digit_index", 32'(digit_index), 32'(k));
            check("decimal_out", 32'(decimal_out), 32'(model_dec(code)));
            check("out_error",   32'(out_error), 32'(code > 9));
            check("out_last",    32'(out_last), 32'(k == 0));
            check("error_count", 32'(error_count), 32'(model_count()));
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (k == 2 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            bcd_in = 16'($urandom);
            @(posedge clk); #1;
            if (out_ready) begin
                if (code > 9) model_err++;
                k--;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("emit_bound", 32'(k < 0), 32'd1);
        check("idle_in_ready",  32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_error_count", 32'(error_count), 32'(model_count()));
        $display("word %h mode %0d done, error_count %0d", w, mode, error_count);
    endtask

    initial begin
        rst       = 1'b1;
        bcd_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12 check_reset_values("por");
        @(posedge clk); #1;
        rst = 1'b0;

        run_word(16'h1905, 0, -1, 1'b0);
        run_word(16'h2468, 2, -1, 1'b0);
        run_word(16'h3A7F, 0, -1, 1'b0);
        check("invalid_count", 32'(error_count), 32'd2);

        run_word(16'h5B12, 0, 1, 1'b0);
        run_word(16'h9999, 0, -1, 1'b0);

        for (int i = 0; i < 4; i++) run_word(16'($urandom), 1, -1, 1'b1);
        for (int i = 0; i < 20; i++) run_word(16'($urandom), 1, -1, 1'b0);

        for (int i = 0; i < 64; i++) run_word(16'hFFFF, 0, -1, 1'b0);
        check("saturated", 32'(error_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
